// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg: shared FSM states, word width and FIFO entry layout for rom_loader
package rom_loader_pkg;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

    localparam int WORD_W   = 16;
    localparam int ADDR_MAX = 32;

    // Address field is sized for the widest supported target; rom_loader uses the low ADDR_BITS
    typedef struct packed {
        logic [ADDR_MAX-1:0] addr;
        logic [WORD_W-1:0]   data;
    } entry_t;

endpackage

// File: rtl/rom_loader_fifo.sv
// rom_loader_fifo: small synchronous word FIFO with simultaneous push/pop and clear
module rom_loader_fifo
    import rom_loader_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic   clk_i,
    input  logic   reset_i,
    input  logic   clear_i,
    input  logic   push_i,
    input  entry_t entry_i,
    input  logic   pop_i,
    output entry_t head_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign head_o  = mem_q[rd_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) mem_q[wr_q] <= entry_i;
            wr_q  <= do_push ? wr_q + PW'(1) : wr_q;
            rd_q  <= do_pop ? rd_q + PW'(1) : rd_q;
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/rom_loader.sv
// rom_loader: packs the ioctl byte download into 16-bit words and writes them to ROM via req/ack
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int ADDR_BITS  = 20,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 ioctl_download_i,
    input  logic                 ioctl_wr_i,
    input  logic [ADDR_BITS:0]   ioctl_addr_i,
    input  logic [7:0]           ioctl_dout_i,
    output logic                 ioctl_wait_o,
    output logic [ADDR_BITS-1:0] mem_addr_o,
    output logic [WORD_W-1:0]    mem_din_o,
    output logic                 mem_we_o,
    input  logic                 mem_ack_i,
    output logic                 rom_loaded_o,
    output logic                 overflow_o
);

    state_t                state_q, state_d;
    logic                  dl_q;
    logic [7:0]            lo_q, lo_d;
    logic                  lo_v_q, lo_v_d;
    logic [ADDR_BITS-1:0]  lo_addr_q, lo_addr_d;
    logic                  we_q, we_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [WORD_W-1:0]     din_q, din_d;
    logic                  loaded_q, loaded_d;
    logic                  ovf_q, ovf_d;
    logic                  go, hi_wr, lo_wr, pad_push, push, pop, issue, full, empty;
    entry_t                push_e, head;
    logic                  unused_head_hi;

    assign go       = ioctl_download_i && !dl_q && (state_q == S_IDLE || state_q == S_DONE);
    assign hi_wr    = state_q == S_LOAD && ioctl_wr_i && ioctl_addr_i[0];
    assign lo_wr    = state_q == S_LOAD && ioctl_wr_i && !ioctl_addr_i[0];
    assign pop      = we_q && mem_ack_i;
    // The odd trailing byte waits for room rather than being dropped
    assign pad_push = state_q == S_FLUSH && lo_v_q && (!full || pop);
    assign push     = hi_wr || pad_push;
    assign issue    = !we_q && !empty;

    assign push_e.addr = ADDR_MAX'(hi_wr ? ioctl_addr_i[ADDR_BITS:1] : lo_addr_q);
    assign push_e.data = hi_wr ? {ioctl_dout_i, lo_v_q ? lo_q : 8'h00} : {8'h00, lo_q};
    assign unused_head_hi = ^head.addr[ADDR_MAX-1:ADDR_BITS];

    rom_loader_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (go),
        .push_i  (push),
        .entry_i (push_e),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        state_d   = go ? S_LOAD :
                    (state_q == S_LOAD && !ioctl_download_i) ? S_FLUSH :
                    (state_q == S_FLUSH && empty && !we_q && !lo_v_q) ? S_DONE : state_q;
        lo_d      = lo_wr ? ioctl_dout_i : lo_q;
        lo_addr_d = lo_wr ? ioctl_addr_i[ADDR_BITS:1] : lo_addr_q;
        lo_v_d    = go ? 1'b0 : lo_wr ? 1'b1 : (hi_wr || pad_push) ? 1'b0 : lo_v_q;
        we_d      = pop ? 1'b0 : issue ? 1'b1 : we_q;
        addr_d    = issue ? head.addr[ADDR_BITS-1:0] : addr_q;
        din_d     = issue ? head.data : din_q;
        loaded_d  = go ? 1'b0 : (state_q == S_DONE) ? 1'b1 : loaded_q;
        ovf_d     = go ? 1'b0 : (hi_wr && full && !pop) ? 1'b1 : ovf_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            dl_q      <= 1'b0;
            lo_q      <= '0;
            lo_v_q    <= 1'b0;
            lo_addr_q <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
            loaded_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dl_q      <= ioctl_download_i;
            lo_q      <= lo_d;
            lo_v_q    <= lo_v_d;
            lo_addr_q <= lo_addr_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            loaded_q  <= loaded_d;
            ovf_q     <= ovf_d;
        end
    end

    assign ioctl_wait_o = full;
    assign mem_addr_o   = addr_q;
    assign mem_din_o    = din_q;
    assign mem_we_o     = we_q;
    assign rom_loaded_o = loaded_q;
    assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: scoreboard bench for rom_loader driving directed ioctl downloads
module tb_rom_loader;
    import rom_loader_pkg::*;

    localparam int AB = 20;

    logic          clk = 1'b0, reset = 1'b1, dl = 1'b0, wr = 1'b0, ack = 1'b0;
    logic [AB:0]   addr = '0;
    logic [7:0]    dout = '0;
    logic          wait_o, we, loaded, ovf;
    logic [AB-1:0] maddr;
    logic [15:0]   mdin;

    int n_chk = 0, n_pass = 0, ack_dly = 0, wcnt = 0;
    bit ack_en = 1'b1, late_ack = 1'b0, wait_seen = 1'b0;

    typedef struct {
        logic [AB-1:0] a;
        logic [15:0]   d;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    rom_loader #(.ADDR_BITS(AB), .FIFO_DEPTH(2)) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .ioctl_download_i (dl),
        .ioctl_wr_i       (wr),
        .ioctl_addr_i     (addr),
        .ioctl_dout_i     (dout),
        .ioctl_wait_o     (wait_o),
        .mem_addr_o       (maddr),
        .mem_din_o        (mdin),
        .mem_we_o         (we),
        .mem_ack_i        (ack),
        .rom_loaded_o     (loaded),
        .overflow_o       (ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic expect_w(input logic [AB-1:0] a, input logic [15:0] d);
        exp_t e;
        e.a = a;
        e.d = d;
        sb.push_back(e);
    endtask

    task automatic put(input logic [31:0] a, input logic [7:0] d, input bit honour);
        int n = 0;
        while (honour && wait_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("wait_timeout", 32'd1, 32'd0);
        wr   = 1'b1;
        addr = a[AB:0];
        dout = d;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic start_dl();
        dl = 1'b1;
        @(negedge clk);
    endtask

    task automatic end_dl(input string name);
        int n = 0;
        dl = 1'b0;
        while (!loaded && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_loaded"}, 32'(loaded), 32'd1);
        chk({name, "_drained"}, 32'(sb.size()), 32'd0);
    endtask

    // Memory model: raise ack ack_dly cycles after mem_we is seen
    always @(posedge clk) begin
        #1;
        if (ack_en && we && !ack) begin
            if (wcnt >= ack_dly) begin
                ack  = 1'b1;
                wcnt = 0;
            end else wcnt++;
        end else begin
            ack  = late_ack;
            wcnt = 0;
        end
    end

    // Monitor: a write commits on the next edge whenever we and ack are both high
    always @(negedge clk) begin
        exp_t e;
        if (wait_o) wait_seen = 1'b1;
        if (!reset && we && ack) begin
            if (sb.size() == 0) chk("spurious_write", 32'(maddr), 32'hFFFF_FFFF);
            else begin
                e = sb.pop_front();
                chk("wr_addr", 32'(maddr), 32'(e.a));
                chk("wr_data", 32'(mdin), 32'(e.d));
            end
        end
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_wait", 32'(wait_o), 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_addr", 32'(maddr), 32'd0);
        chk("rst_din", 32'(mdin), 32'd0);
        chk("rst_loaded", 32'(loaded), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        ack_dly = 0;
        wait_seen = 1'b0;
        start_dl();
        expect_w(20'd0, 16'h2211);
        expect_w(20'd1, 16'h4433);
        put(0, 8'h11, 1);
        put(1, 8'h22, 1);
        put(2, 8'h33, 1);
        put(3, 8'h44, 1);
        end_dl("t1");
        chk("t1_wait_never", 32'(wait_seen), 32'd0);
        chk("t1_ovf", 32'(ovf), 32'd0);

        ack_dly = 6;
        wait_seen = 1'b0;
        start_dl();
        chk("t2_loaded_clr", 32'(loaded), 32'd0);
        for (int i = 0; i < 8; i++) expect_w(AB'(i), {8'(2 * i + 2), 8'(2 * i + 1)});
        for (int j = 0; j < 4; j++) put(32'(j), 8'(j + 1), 1);
        chk("t2_wait_after_2nd", 32'(wait_o), 32'd1);
        for (int j = 4; j < 16; j++) put(32'(j), 8'(j + 1), 1);
        end_dl("t2");
        chk("t2_wait_seen", 32'(wait_seen), 32'd1);
        chk("t2_ovf", 32'(ovf), 32'd0);

        ack_dly = 2;
        start_dl();
        expect_w(20'd0, 16'hA1A0);
        expect_w(20'd1, 16'hA3A2);
        expect_w(20'd2, 16'h00A4);
        for (int j = 0; j < 5; j++) put(32'(j), 8'hA0 + 8'(j), 1);
        dl = 1'b0;
        n = 0;
        while (!(we && maddr == 20'd2) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t3_pad_issued", 32'(we && maddr == 20'd2), 32'd1);
        chk("t3_pad_in_flush", 32'(dut.state_q), 32'(S_FLUSH));
        chk("t3_not_loaded", 32'(loaded), 32'd0);
        end_dl("t3");

        ack_dly = 10;
        start_dl();
        chk("t4_loaded_clr", 32'(loaded), 32'd0);
        expect_w(20'd0, 16'hB1B0);
        expect_w(20'd1, 16'hB3B2);
        expect_w(20'd3, 16'hB7B6);
        put(0, 8'hB0, 1);
        put(1, 8'hB1, 1);
        put(2, 8'hB2, 1);
        put(3, 8'hB3, 1);
        chk("t4_wait_high", 32'(wait_o), 32'd1);
        put(4, 8'hB4, 0);
        put(5, 8'hB5, 0);
        chk("t4_ovf_set", 32'(ovf), 32'd1);
        put(6, 8'hB6, 1);
        put(7, 8'hB7, 1);
        end_dl("t4");
        chk("t4_ovf_sticky", 32'(ovf), 32'd1);

        ack_dly = 0;
        start_dl();
        chk("t5_ovf_clr", 32'(ovf), 32'd0);
        chk("t5_loaded_clr", 32'(loaded), 32'd0);
        expect_w(20'hFFFFF, 16'hC1C0);
        expect_w(20'h00000, 16'hC3C2);
        put(32'h1FFFFE, 8'hC0, 1);
        put(32'h1FFFFF, 8'hC1, 1);
        put(32'h200000, 8'hC2, 1);
        put(32'h200001, 8'hC3, 1);
        end_dl("t5");

        ack_en = 1'b0;
        start_dl();
        put(0, 8'hD0, 1);
        put(1, 8'hD1, 1);
        n = 0;
        while (!we && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t6_we_before_rst", 32'(we), 32'd1);
        reset = 1'b1;
        dl = 1'b0;
        @(negedge clk);
        chk("t6_we_dropped", 32'(we), 32'd0);
        chk("t6_loaded", 32'(loaded), 32'd0);
        chk("t6_state_idle", 32'(dut.state_q), 32'(S_IDLE));
        reset = 1'b0;
        late_ack = 1'b1;
        repeat (2) @(negedge clk);
        late_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_no_we_after_late_ack", 32'(we), 32'd0);
        chk("t6_wait", 32'(wait_o), 32'd0);
        chk("t6_ovf", 32'(ovf), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
